bus_grant_arbiter: RTL and testbench
====================================

Name: bus_grant_arbiter

Overview:
Sequential round-robin arbiter that produces the 32-bit one-hot bus-source select vector consumed by the 32-to-5 bus encoder. Sits between the control/sequencing logic, which raises per-source bus requests, and the encoder/bus mux.
Guarantees at most one grant bit high per cycle, so the encoder never sees a multi-hot input. Supports multi-cycle locked tenure with a bounded hold limit.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one source may keep a locked grant while other sources are requesting (legal range 1..15).

Ports:
clock  input  1  system clock; all state updates on the rising edge
clear  input  1  synchronous, active-high reset
stall  input  1  when 1, all internal state and outputs hold; clear overrides stall
req    input  32  per-source bus request; bit i = source i (encoder index i)
lock   input  1  current owner requests to keep the bus beyond this cycle
grant  output  32  registered one-hot grant, or all-zero; feeds the encoder input
busy   output  1  1 when grant is non-zero (state GRANT)
forced  output  1  one-cycle pulse: a locked owner was preempted by the MAX_HOLD limit

Behaviour:
- Internal state: state {IDLE, GRANT}, owner[4:0], ptr[4:0] (round-robin start index), hold_cnt[3:0].
- Reset (clear=1 at an edge): grant=0, busy=0, forced=0, state=IDLE, owner=0, ptr=0, hold_cnt=0. Takes effect at that edge regardless of req, lock or stall.
- Clear mid-tenure drops the grant at that edge. Arbitration resumes on the first edge after clear deasserts, using ptr=0.
- Latency: req sampled at edge t; the resulting grant is visible from edge t through edge t+1. No combinational path from req to grant.
- Arbitrate(req): choose the first set bit scanning ptr, ptr+1, ..., 31, 0, ..., ptr-1 (mod 32).
  - If one is found, call its index w: grant<=1<<w, owner<=w, ptr<=(w+1) mod 32 (31 wraps to 0), hold_cnt<=1, state<=GRANT.
  - If none is found: grant<=0, state<=IDLE, ptr unchanged.
- IDLE: Arbitrate(req) every non-stalled edge.
- GRANT, req[owner]=0: Arbitrate(req). The released owner cannot be re-picked because its req bit is low.
- GRANT, req[owner]=1, lock=0: Arbitrate(req).
  - Because ptr=owner+1, every other requester wins before the owner.
  - If the owner is the only requester, it is re-granted with hold_cnt<=1.
- GRANT, req[owner]=1, lock=1, hold_cnt<MAX_HOLD: grant unchanged, hold_cnt<=hold_cnt+1, ptr unchanged.
- GRANT, req[owner]=1, lock=1, hold_cnt==MAX_HOLD:
  - If any other req bit is set: Arbitrate(req) with the owner's bit masked off, and forced<=1 for exactly one cycle.
  - Otherwise the grant is kept, hold_cnt saturates at MAX_HOLD, and forced<=0.
- forced is 0 in all other cases; it is a registered pulse aligned with the new grant.
- stall=1 with clear=0: grant, busy, forced, state, owner, ptr and hold_cnt all hold. forced is not re-pulsed on release of stall.
- Invariant: grant has popcount 0 or 1 every cycle; busy == (grant != 0).
- Simultaneous release and new requests: the new grant appears on the same edge as the release, with no idle bubble.

Test Plan:
- Reset: hold clear=1 with req=32'hFFFFFFFF and lock=1 for 2 edges -> grant=0, busy=0, forced=0. Release clear -> next edge grant=32'h00000001.
- Round-robin: req=32'h80000005, lock=0, held for 4 edges -> grant sequence 0x00000001, 0x00000004, 0x80000000, 0x00000001 (wrap from 31 to 0).
- Locked tenure limit: MAX_HOLD=4, req=32'h00000006, lock=1 from reset -> grant=0x2 for 4 cycles, then grant=0x4 with forced=1 for one cycle.
  - Lock held with only req=32'h2 -> grant stays 0x2 indefinitely, forced stays 0.
- Release handoff: owner bit 3 granted, then req changes from 0x00000018 to 0x00000010 in one cycle -> next edge grant=0x10. Then req=0 -> grant=0, busy=0.
- Stall/clear interaction: stall=1 during a locked tenure with hold_cnt=2 -> grant frozen for 5 cycles and hold_cnt not advanced.
  - Assert clear while stall=1 -> grant=0 at that edge.
- Random regression: 10k cycles of random req, lock and stall -> popcount(grant)≤1 every cycle, and no requester waits more than 31*MAX_HOLD+31 cycles.

Source files
------------

// File: rtl/bus_grant_arbiter.sv
// rtl/bus_grant_arbiter.sv - round-robin one-hot bus grant arbiter with bounded locked tenure
module bus_grant_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        stall,
  input  logic [31:0] req,
  input  logic        lock,
  output logic [31:0] grant,
  output logic        busy,
  output logic        forced
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t      state, state_nx;
  logic [4:0]  owner, owner_nx;
  logic [4:0]  ptr, ptr_nx;
  logic [3:0]  hold_cnt, hold_nx;
  logic [31:0] grant_nx;
  logic        forced_nx;

  logic        owner_held;
  logic        hold_expired;
  logic [31:0] arb_vec;
  logic        found;
  logic [4:0]  win;

  assign owner_held   = (state == GRANT) && req[owner];
  assign hold_expired = owner_held && lock && (hold_cnt >= HOLD_LIMIT);
  // At the hold limit the owner competes with its own bit removed so any other requester wins.
  assign arb_vec      = hold_expired ? (req & ~(32'b1 << owner)) : req;

  always_comb begin
    logic [4:0] idx;
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int i = 0; i < 32; i++) begin
      idx = ptr + 5'(i);
      if (!found && arb_vec[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    grant_nx  = grant;
    forced_nx = 1'b0;
    if (owner_held && lock && !hold_expired) begin
      hold_nx = hold_cnt + 4'd1;
    end else if (hold_expired && !found) begin
      // Sole requester past the limit: keep the grant, counter stays saturated.
      hold_nx = hold_cnt;
    end else if (found) begin
      grant_nx  = 32'b1 << win;
      owner_nx  = win;
      ptr_nx    = win + 5'd1;
      hold_nx   = 4'd1;
      state_nx  = GRANT;
      forced_nx = hold_expired;
    end else begin
      grant_nx = '0;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      forced   <= 1'b0;
    end else if (!stall) begin
      state    <= state_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      grant    <= grant_nx;
      forced   <= forced_nx;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// tb/tb_bus_grant_arbiter.sv - directed and random self-checking bench for bus_grant_arbiter
module tb_bus_grant_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int WAIT_BOUND = 31 * MAX_HOLD + 31;

  logic        clock = 1'b0;
  logic        clear, stall, lock;
  logic [31:0] req;
  logic [31:0] grant;
  logic        busy, forced;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, where the scan starts, how long the tenure has run.
  bit m_busy;
  int m_owner, m_ptr, m_hold;
  bit m_forced;
  int waits[32];
  int max_wait;

  bus_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .clear (clear),
    .stall (stall),
    .req   (req),
    .lock  (lock),
    .grant (grant),
    .busy  (busy),
    .forced(forced)
  );

  always #5 clock = ~clock;

  function automatic int first_from(logic [31:0] vec, int start);
    for (int k = 0; k < 32; k++) begin
      int idx = (start + k) % 32;
      if (vec[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic award(int w);
    if (w < 0) begin
      m_busy = 1'b0;
    end else begin
      m_busy  = 1'b1;
      m_owner = w;
      m_ptr   = (w + 1) % 32;
      m_hold  = 1;
    end
  endtask

  task automatic model_step();
    logic [31:0] others;
    if (clear) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_forced = 0;
    end else if (!stall) begin
      m_forced = 0;
      if (m_busy && req[m_owner] && lock) begin
        if (m_hold < MAX_HOLD) begin
          m_hold = m_hold + 1;
        end else begin
          others = req & ~(32'h1 << m_owner);
          if (others != 0) begin
            award(first_from(others, m_ptr));
            m_forced = 1;
          end
        end
      end else begin
        award(first_from(req, m_ptr));
      end
    end
  endtask

  function automatic logic [31:0] model_grant();
    return m_busy ? (32'h1 << m_owner) : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    model_step();
    if (clear) begin
      for (int i = 0; i < 32; i++) waits[i] = 0;
    end else if (!stall) begin
      for (int i = 0; i < 32; i++)
        waits[i] = (req[i] && !grant[i]) ? waits[i] + 1 : 0;
    end
    max_wait = 0;
    for (int i = 0; i < 32; i++) if (waits[i] > max_wait) max_wait = waits[i];
  endtask

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  initial begin
    logic [31:0] rr_exp [4];
    clear = 1; stall = 0; lock = 1; req = 32'hFFFFFFFF;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_forced = 0;
    for (int i = 0; i < 32; i++) waits[i] = 0;

    tick(); tick();
    check("reset_grant", grant, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_forced", {31'b0, forced}, 32'h0);
    clear = 0; lock = 0;
    tick();
    check("post_reset_grant", grant, 32'h00000001);
    check("post_reset_busy", {31'b0, busy}, 32'h1);

    do_clear();
    req = 32'h80000005; lock = 0;
    rr_exp[0] = 32'h00000001; rr_exp[1] = 32'h00000004;
    rr_exp[2] = 32'h80000000; rr_exp[3] = 32'h00000001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_%0d", i), grant, rr_exp[i]);
    end

    do_clear();
    req = 32'h00000006; lock = 1;
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      check($sformatf("lock_hold_%0d", i), grant, 32'h2);
      check($sformatf("lock_noforce_%0d", i), {31'b0, forced}, 32'h0);
    end
    tick();
    check("lock_preempt_grant", grant, 32'h4);
    check("lock_preempt_forced", {31'b0, forced}, 32'h1);
    tick();
    check("forced_pulse_ends", {31'b0, forced}, 32'h0);

    do_clear();
    req = 32'h00000002; lock = 1;
    for (int i = 0; i < 8; i++) tick();
    check("sole_lock_grant", grant, 32'h2);
    check("sole_lock_forced", {31'b0, forced}, 32'h0);

    do_clear();
    req = 32'h00000018; lock = 1;
    tick();
    check("handoff_owner3", grant, 32'h8);
    req = 32'h00000010;
    tick();
    check("handoff_next", grant, 32'h10);
    req = 32'h0;
    tick();
    check("handoff_idle_grant", grant, 32'h0);
    check("handoff_idle_busy", {31'b0, busy}, 32'h0);

    do_clear();
    req = 32'h00000006; lock = 1;
    tick(); tick();
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_frozen_%0d", i), grant, 32'h2);
    end
    stall = 0;
    tick(); tick();
    check("stall_hold_not_advanced", grant, 32'h2);
    tick();
    check("stall_then_preempt", grant, 32'h4);
    check("stall_then_forced", {31'b0, forced}, 32'h1);
    stall = 1;
    tick();
    check("stall_forced_held", {31'b0, forced}, 32'h1);
    clear = 1;
    tick();
    check("clear_over_stall", grant, 32'h0);
    clear = 0; stall = 0;

    for (int n = 0; n < 10000; n++) begin
      clear = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 9) == 0);
      lock  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: req = $urandom;
        1: req = $urandom & $urandom & $urandom;
        2: req = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
        default: req = req;
      endcase
      tick();
      check("rnd_grant", grant, model_grant());
      check("rnd_busy", {31'b0, busy}, {31'b0, m_busy});
      check("rnd_forced", {31'b0, forced}, {31'b0, m_forced});
      check("rnd_onehot", {31'b0, ($countones(grant) <= 1)}, 32'h1);
      check("rnd_wait_bound", {31'b0, (max_wait <= WAIT_BOUND)}, 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
